// File: rtl/fp_div_arbiter_if.sv
// ---------------------------------------------------------------------------
// fp_div_arbiter_if
// Bundles the two client channels and the divider channels of fp_div_arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fp_div_arbiter_if;
   logic [31:0] c0_a;
   logic [31:0] c0_b;
   logic        c0_stb;
   logic        c0_ack;
   logic [31:0] c0_z;
   logic        c0_z_stb;
   logic        c0_z_ack;

   logic [31:0] c1_a;
   logic [31:0] c1_b;
   logic        c1_stb;
   logic        c1_ack;
   logic [31:0] c1_z;
   logic        c1_z_stb;
   logic        c1_z_ack;

   logic [31:0] div_a;
   logic        div_a_stb;
   logic        div_a_ack;
   logic [31:0] div_b;
   logic        div_b_stb;
   logic        div_b_ack;
   logic [31:0] div_z;
   logic        div_z_stb;
   logic        div_z_ack;

   // Environment side: clients and divider.
   modport master (
      output c0_a, c0_b, c0_stb, c0_z_ack,
      input  c0_ack, c0_z, c0_z_stb,
      output c1_a, c1_b, c1_stb, c1_z_ack,
      input  c1_ack, c1_z, c1_z_stb,
      input  div_a, div_a_stb, div_b, div_b_stb, div_z_ack,
      output div_a_ack, div_b_ack, div_z, div_z_stb
   );

   // Arbiter side.
   modport slave (
      input  c0_a, c0_b, c0_stb, c0_z_ack,
      output c0_ack, c0_z, c0_z_stb,
      input  c1_a, c1_b, c1_stb, c1_z_ack,
      output c1_ack, c1_z, c1_z_stb,
      output div_a, div_a_stb, div_b, div_b_stb, div_z_ack,
      input  div_a_ack, div_b_ack, div_z, div_z_stb
   );
endinterface

`default_nettype wire

// File: rtl/fp_div_arbiter.sv
// ---------------------------------------------------------------------------
// fp_div_arbiter
// Round-robin sharing of one IEEE single divider between two clients, one
// division in flight, with per-client completion counters.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_div_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   fp_div_arbiter_if.slave  bus,
   output logic [CNT_W-1:0] done_cnt0,
   output logic [CNT_W-1:0] done_cnt1
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCEPT = 3'd1,
      S_SEND_A = 3'd2,
      S_SEND_B = 3'd3,
      S_WAIT_Z = 3'd4,
      S_PUT_Z  = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic             grant_q, grant_d;
   logic             last_q, last_d;
   logic [31:0]      b_q, b_d;
   logic             ack0_q, ack0_d, ack1_q, ack1_d;
   logic [31:0]      z0_q, z0_d, z1_q, z1_d;
   logic             zstb0_q, zstb0_d, zstb1_q, zstb1_d;
   logic [31:0]      diva_q, diva_d, divb_q, divb_d;
   logic             astb_q, astb_d, bstb_q, bstb_d, zack_q, zack_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   // Signals of the currently granted client.
   logic             w_stb, w_ack, w_zstb, w_zack;
   logic [31:0]      w_a, w_b;

   assign w_stb  = grant_q ? bus.c1_stb   : bus.c0_stb;
   assign w_ack  = grant_q ? ack1_q       : ack0_q;
   assign w_a    = grant_q ? bus.c1_a     : bus.c0_a;
   assign w_b    = grant_q ? bus.c1_b     : bus.c0_b;
   assign w_zstb = grant_q ? zstb1_q      : zstb0_q;
   assign w_zack = grant_q ? bus.c1_z_ack : bus.c0_z_ack;

   // State and output registers; reset drops any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         b_q     <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         z0_q    <= '0;
         z1_q    <= '0;
         zstb0_q <= 1'b0;
         zstb1_q <= 1'b0;
         diva_q  <= '0;
         divb_q  <= '0;
         astb_q  <= 1'b0;
         bstb_q  <= 1'b0;
         zack_q  <= 1'b0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         b_q     <= b_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         z0_q    <= z0_d;
         z1_q    <= z1_d;
         zstb0_q <= zstb0_d;
         zstb1_q <= zstb1_d;
         diva_q  <= diva_d;
         divb_q  <= divb_d;
         astb_q  <= astb_d;
         bstb_q  <= bstb_d;
         zack_q  <= zack_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   // Next-state logic: arbitrate, then walk the operation through a, b, z.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      b_d     = b_q;
      ack0_d  = ack0_q;
      ack1_d  = ack1_q;
      z0_d    = z0_q;
      z1_d    = z1_q;
      zstb0_d = zstb0_q;
      zstb1_d = zstb1_q;
      diva_d  = diva_q;
      divb_d  = divb_q;
      astb_d  = astb_q;
      bstb_d  = bstb_q;
      zack_d  = zack_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;

      case (state_q)
         S_IDLE: begin
            if (bus.c0_stb || bus.c1_stb) begin
               // On a tie the client that was not served last wins.
               if (bus.c0_stb && bus.c1_stb) grant_d = ~last_q;
               else                          grant_d = bus.c1_stb;
               ack0_d  = ~grant_d;
               ack1_d  = grant_d;
               state_d = S_ACCEPT;
            end
         end
         S_ACCEPT: begin
            if (w_stb && w_ack) begin
               b_d     = w_b;
               ack0_d  = 1'b0;
               ack1_d  = 1'b0;
               diva_d  = w_a;
               astb_d  = 1'b1;
               state_d = S_SEND_A;
            end
         end
         S_SEND_A: begin
            if (astb_q && bus.div_a_ack) begin
               astb_d  = 1'b0;
               divb_d  = b_q;
               bstb_d  = 1'b1;
               state_d = S_SEND_B;
            end
         end
         S_SEND_B: begin
            if (bstb_q && bus.div_b_ack) begin
               bstb_d  = 1'b0;
               zack_d  = 1'b1;
               state_d = S_WAIT_Z;
            end
         end
         S_WAIT_Z: begin
            if (zack_q && bus.div_z_stb) begin
               zack_d = 1'b0;
               if (grant_q) begin
                  z1_d    = bus.div_z;
                  zstb1_d = 1'b1;
               end else begin
                  z0_d    = bus.div_z;
                  zstb0_d = 1'b1;
               end
               state_d = S_PUT_Z;
            end
         end
         S_PUT_Z: begin
            if (w_zstb && w_zack) begin
               zstb0_d = 1'b0;
               zstb1_d = 1'b0;
               if (grant_q) cnt1_d = cnt1_q + 1'b1;
               else         cnt0_d = cnt0_q + 1'b1;
               last_d  = grant_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.c0_ack    = ack0_q;
   assign bus.c1_ack    = ack1_q;
   assign bus.c0_z      = z0_q;
   assign bus.c1_z      = z1_q;
   assign bus.c0_z_stb  = zstb0_q;
   assign bus.c1_z_stb  = zstb1_q;
   assign bus.div_a     = diva_q;
   assign bus.div_a_stb = astb_q;
   assign bus.div_b     = divb_q;
   assign bus.div_b_stb = bstb_q;
   assign bus.div_z_ack = zack_q;
   assign done_cnt0     = cnt0_q;
   assign done_cnt1     = cnt1_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_div_arbiter
// Directed bench: two arbiter instances (CNT_W=16 and CNT_W=2); the bench
// plays both clients and the divider with hand-computed quotients.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp_div_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel = 1'b0;   // 0: instance A (CNT_W=16), 1: instance B (CNT_W=2)

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Bench-side drives, routed to the selected instance.
   logic [31:0] c0_a = '0, c0_b = '0, c1_a = '0, c1_b = '0, div_z = '0;
   logic c0_stb = 0, c1_stb = 0, c0_z_ack = 0, c1_z_ack = 0;
   logic div_a_ack = 0, div_b_ack = 0, div_z_stb = 0;

   fp_div_arbiter_if ifA ();
   fp_div_arbiter_if ifB ();
   logic [15:0] cntA0, cntA1;
   logic [1:0]  cntB0, cntB1;

   fp_div_arbiter #(.CNT_W(16)) dutA (.clk(clk), .rst(rst), .bus(ifA), .done_cnt0(cntA0), .done_cnt1(cntA1));
   fp_div_arbiter #(.CNT_W(2))  dutB (.clk(clk), .rst(rst), .bus(ifB), .done_cnt0(cntB0), .done_cnt1(cntB1));

   assign ifA.c0_a = c0_a;  assign ifA.c0_b = c0_b;  assign ifA.c1_a = c1_a;  assign ifA.c1_b = c1_b;
   assign ifB.c0_a = c0_a;  assign ifB.c0_b = c0_b;  assign ifB.c1_a = c1_a;  assign ifB.c1_b = c1_b;
   assign ifA.div_z = div_z; assign ifB.div_z = div_z;
   assign ifA.c0_stb    = c0_stb & ~sel;    assign ifB.c0_stb    = c0_stb & sel;
   assign ifA.c1_stb    = c1_stb & ~sel;    assign ifB.c1_stb    = c1_stb & sel;
   assign ifA.c0_z_ack  = c0_z_ack & ~sel;  assign ifB.c0_z_ack  = c0_z_ack & sel;
   assign ifA.c1_z_ack  = c1_z_ack & ~sel;  assign ifB.c1_z_ack  = c1_z_ack & sel;
   assign ifA.div_a_ack = div_a_ack & ~sel; assign ifB.div_a_ack = div_a_ack & sel;
   assign ifA.div_b_ack = div_b_ack & ~sel; assign ifB.div_b_ack = div_b_ack & sel;
   assign ifA.div_z_stb = div_z_stb & ~sel; assign ifB.div_z_stb = div_z_stb & sel;

   logic        o_c0_ack, o_c1_ack, o_c0_z_stb, o_c1_z_stb;
   logic        o_div_a_stb, o_div_b_stb, o_div_z_ack;
   logic [31:0] o_c0_z, o_c1_z, o_div_a, o_div_b;
   logic [15:0] cnt0, cnt1;

   assign o_c0_ack    = sel ? ifB.c0_ack    : ifA.c0_ack;
   assign o_c1_ack    = sel ? ifB.c1_ack    : ifA.c1_ack;
   assign o_c0_z_stb  = sel ? ifB.c0_z_stb  : ifA.c0_z_stb;
   assign o_c1_z_stb  = sel ? ifB.c1_z_stb  : ifA.c1_z_stb;
   assign o_c0_z      = sel ? ifB.c0_z      : ifA.c0_z;
   assign o_c1_z      = sel ? ifB.c1_z      : ifA.c1_z;
   assign o_div_a_stb = sel ? ifB.div_a_stb : ifA.div_a_stb;
   assign o_div_b_stb = sel ? ifB.div_b_stb : ifA.div_b_stb;
   assign o_div_z_ack = sel ? ifB.div_z_ack : ifA.div_z_ack;
   assign o_div_a     = sel ? ifB.div_a     : ifA.div_a;
   assign o_div_b     = sel ? ifB.div_b     : ifA.div_b;
   assign cnt0        = sel ? {14'd0, cntB0} : cntA0;
   assign cnt1        = sel ? {14'd0, cntB1} : cntA1;

   // Sticky record of any client-1 ack since the last clear.
   logic seen_clr = 1'b0;
   logic c1_seen  = 1'b0;
   always @(posedge clk) begin
      if (seen_clr)      c1_seen <= 1'b0;
      else if (o_c1_ack) c1_seen <= 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      c0_stb = 0; c1_stb = 0; c0_z_ack = 0; c1_z_ack = 0;
      div_a_ack = 0; div_b_ack = 0; div_z_stb = 0; div_z = '0;
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " hs"}, {o_c0_ack, o_c1_ack, o_c0_z_stb, o_c1_z_stb, o_div_a_stb, o_div_b_stb, o_div_z_ack}, 0);
      chk({tag, " c0_z"}, o_c0_z, 0);
      chk({tag, " c1_z"}, o_c1_z, 0);
      chk({tag, " div_a"}, o_div_a, 0);
      chk({tag, " div_b"}, o_div_b, 0);
      chk({tag, " cnts"}, {cnt0, cnt1}, 0);
   endtask

   task automatic wait_ack(input int exp_c, input string tag);
      int n = 0;
      while (!(o_c0_ack || o_c1_ack) && n < 200) begin @(negedge clk); n++; end
      chk({tag, " ack timeout"}, n < 200, 1);
      chk({tag, " ack who"}, {o_c0_ack, o_c1_ack}, exp_c[0] ? 2'b01 : 2'b10);
      @(negedge clk);
      chk({tag, " ack drop"}, {o_c0_ack, o_c1_ack}, 0);
   endtask

   task automatic div_serve(input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] z,
                            input int a_stall, input int z_stall, input string tag);
      int n = 0;
      while (!o_div_a_stb && n < 200) begin @(negedge clk); n++; end
      chk({tag, " a timeout"}, n < 200, 1);
      for (int i = 0; i < a_stall; i++) begin
         @(negedge clk);
         chk({tag, " a hold"}, {o_div_a_stb, o_c0_ack | o_c1_ack, o_div_a}, {2'b10, ea});
      end
      chk({tag, " div_a"}, o_div_a, ea);
      div_a_ack = 1; @(negedge clk); div_a_ack = 0;
      chk({tag, " b stb"}, {o_div_a_stb, o_div_b_stb}, 2'b01);
      chk({tag, " div_b"}, o_div_b, eb);
      div_b_ack = 1; @(negedge clk); div_b_ack = 0;
      chk({tag, " z ack"}, {o_div_b_stb, o_div_z_ack}, 2'b01);
      for (int i = 0; i < z_stall; i++) begin
         @(negedge clk);
         chk({tag, " z wait"}, {o_div_z_ack, o_c0_z_stb | o_c1_z_stb, o_c0_ack | o_c1_ack}, 3'b100);
      end
      div_z = z; div_z_stb = 1; @(negedge clk); div_z_stb = 0;
      chk({tag, " z ack drop"}, o_div_z_ack, 0);
   endtask

   task automatic take_z(input int exp_c, input logic [31:0] ez, input int hold, input string tag);
      int n = 0;
      logic [31:0] zo;
      while (!(o_c0_z_stb || o_c1_z_stb) && n < 200) begin @(negedge clk); n++; end
      chk({tag, " z timeout"}, n < 200, 1);
      chk({tag, " z who"}, {o_c0_z_stb, o_c1_z_stb}, exp_c[0] ? 2'b01 : 2'b10);
      zo = exp_c[0] ? o_c1_z : o_c0_z;
      chk({tag, " z"}, zo, ez);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         zo = exp_c[0] ? o_c1_z : o_c0_z;
         chk({tag, " z hold"}, {exp_c[0] ? o_c1_z_stb : o_c0_z_stb, zo}, {1'b1, ez});
      end
      if (exp_c[0]) c1_z_ack = 1; else c0_z_ack = 1;
      @(negedge clk);
      c0_z_ack = 0; c1_z_ack = 0;
      chk({tag, " z drop"}, {o_c0_z_stb, o_c1_z_stb}, 0);
   endtask

   // Full operation for client c whose stb is already up; optionally drops stb after acceptance.
   task automatic serve(input int c, input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
                        input bit drop, input string tag);
      wait_ack(c, tag);
      if (drop) begin
         if (c == 0) c0_stb = 0; else c1_stb = 0;
      end
      div_serve(a, b, z, 0, 0, tag);
      take_z(c, z, 0, tag);
   endtask

   initial begin
      int cnt_seq[5];
      cnt_seq = '{1, 2, 3, 0, 1};

      // Reset state.
      do_reset();
      chk_idle("reset");

      // Client 0 alone: 6.0 / 2.0 = 3.0.
      seen_clr = 1; @(negedge clk); seen_clr = 0;
      c0_a = 32'h40C00000; c0_b = 32'h40000000; c0_stb = 1;
      serve(0, 32'h40C00000, 32'h40000000, 32'h40400000, 1, "solo");
      chk("solo cnts", {cnt0, cnt1}, {16'd1, 16'd0});
      chk("solo c1 ack never", c1_seen, 0);

      // Simultaneous requests: c0 1/3 then c1 1/0.
      do_reset();
      c0_a = 32'h3F800000; c0_b = 32'h40400000;
      c1_a = 32'h3F800000; c1_b = 32'h00000000;
      c0_stb = 1; c1_stb = 1;
      serve(0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1, "tie c0");
      serve(1, 32'h3F800000, 32'h00000000, 32'h7F800000, 1, "tie c1");
      chk("tie cnts", {cnt0, cnt1}, {16'd1, 16'd1});

      // Continuous requests from both: grants alternate, one IDLE cycle between.
      do_reset();
      c0_a = 32'h41200000; c0_b = 32'h40A00000;
      c1_a = 32'h41100000; c1_b = 32'h40400000;
      c0_stb = 1; c1_stb = 1;
      serve(0, 32'h41200000, 32'h40A00000, 32'h40000000, 0, "rr0");
      @(negedge clk);
      chk("rr1 back-to-back", {o_c0_ack, o_c1_ack}, 2'b01);
      serve(1, 32'h41100000, 32'h40400000, 32'h40400000, 0, "rr1");
      @(negedge clk);
      chk("rr2 back-to-back", {o_c0_ack, o_c1_ack}, 2'b10);
      serve(0, 32'h41200000, 32'h40A00000, 32'h40000000, 0, "rr2");
      @(negedge clk);
      chk("rr3 back-to-back", {o_c0_ack, o_c1_ack}, 2'b01);
      serve(1, 32'h41100000, 32'h40400000, 32'h40400000, 0, "rr3");
      c0_stb = 0; c1_stb = 0;
      chk("rr cnts", {cnt0, cnt1}, {16'd2, 16'd2});

      // Stalls on the divider and on client 1's result.
      do_reset();
      c1_a = 32'h40E00000; c1_b = 32'h40000000; c1_stb = 1;
      wait_ack(1, "stall");
      c1_stb = 0;
      div_serve(32'h40E00000, 32'h40000000, 32'h40600000, 10, 20, "stall");
      take_z(1, 32'h40600000, 5, "stall");
      chk("stall cnts", {cnt0, cnt1}, {16'd0, 16'd1});

      // Reset while waiting for the quotient.
      do_reset();
      c0_a = 32'h40C00000; c0_b = 32'h40000000; c0_stb = 1;
      serve(0, 32'h40C00000, 32'h40000000, 32'h40400000, 1, "pre");
      chk("pre cnt0", cnt0, 1);
      c0_a = 32'h41200000; c0_b = 32'h40A00000; c0_stb = 1;
      wait_ack(0, "midrst");
      c0_stb = 0;
      div_a_ack = 1; @(negedge clk); div_a_ack = 0;
      div_b_ack = 1; @(negedge clk); div_b_ack = 0;
      chk("midrst in wait_z", o_div_z_ack, 1);
      rst = 1; @(negedge clk); rst = 0;
      chk_idle("midrst");
      c0_stb = 1;
      @(negedge clk);
      chk("midrst idle grant", {o_c0_ack, o_c1_ack}, 2'b10);
      serve(0, 32'h41200000, 32'h40A00000, 32'h40000000, 1, "post");
      chk("post cnts", {cnt0, cnt1}, {16'd1, 16'd0});

      // Narrow counter instance wraps modulo 4.
      sel = 1;
      do_reset();
      chk_idle("w2 reset");
      c0_a = 32'h3F800000; c0_b = 32'h40000000;
      for (int k = 0; k < 5; k++) begin
         c0_stb = 1;
         serve(0, 32'h3F800000, 32'h40000000, 32'h3F000000, 1, "w2");
         chk($sformatf("w2 cnt0 op%0d", k), cnt0, cnt_seq[k]);
      end
      chk("w2 cnt1", cnt1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/fp_div_arbiter.md
Name: fp_div_arbiter

Overview:
Shares one single-precision IEEE divider between two requesters (client 0, client 1) using round-robin arbitration.
- Each client hands over an operand pair in one stb/ack transfer and later receives the 32-bit quotient on its own stb/ack result channel.
- The arbiter feeds the divider's a, b and z stb/ack channels in sequence and keeps exactly one division in flight.
- It also keeps per-client completion counters for performance monitoring.

Parameters:
CNT_W, 16, width of each per-client completed-operation counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
c0_a  input  32  client 0 dividend (IEEE single)
c0_b  input  32  client 0 divisor (IEEE single)
c0_stb  input  1  client 0 operand pair valid
c0_ack  output  1  client 0 operand pair accepted
c0_z  output  32  client 0 quotient
c0_z_stb  output  1  client 0 quotient valid
c0_z_ack  input  1  client 0 quotient taken
c1_a, c1_b, c1_stb, c1_ack, c1_z, c1_z_stb, c1_z_ack  same as client 0, for client 1
div_a  output  32  operand a to divider
div_a_stb  output  1  operand a valid
div_a_ack  input  1  divider accepts a
div_b  output  32  operand b to divider
div_b_stb  output  1  operand b valid
div_b_ack  input  1  divider accepts b
div_z  input  32  divider result
div_z_stb  input  1  divider result valid
div_z_ack  output  1  arbiter takes result
done_cnt0  output  CNT_W  results delivered to client 0
done_cnt1  output  CNT_W  results delivered to client 1

Behaviour:
- Transfer rule, all channels: a transfer occurs on a rising edge where stb and ack are both high. The producer holds stb and data stable until that edge. All arbiter outputs are registered.
- Reset: state=IDLE, last_grant=1 (client 0 wins the first tie), grant=0. All of c*_ack, c*_z_stb, div_a_stb, div_b_stb, div_z_ack, done_cnt0, done_cnt1 = 0. Data outputs (c*_z, div_a, div_b) = 0.
- Reset mid-operation: any in-flight operation and pending result are discarded; no counter increment. The divider shares rst, so it also returns to its operand-a wait.
- States:
  - IDLE: if exactly one c*_stb is high, grant that client. If both are high, grant the client != last_grant. Set c[grant]_ack<=1 and go to ACCEPT. If neither is high, stay.
  - ACCEPT: on c[grant]_stb && c[grant]_ack, latch a and b, set c[grant]_ack<=0, set div_a<=a, div_a_stb<=1, go to SEND_A.
  - SEND_A: on div_a_stb && div_a_ack, set div_a_stb<=0, div_b<=b, div_b_stb<=1, go to SEND_B.
  - SEND_B: on div_b_stb && div_b_ack, set div_b_stb<=0, div_z_ack<=1, go to WAIT_Z.
  - WAIT_Z: on div_z_stb && div_z_ack, latch div_z, set div_z_ack<=0, c[grant]_z<=div_z, c[grant]_z_stb<=1, go to PUT_Z. Waits unbounded; no timeout.
  - PUT_Z: on c[grant]_z_stb && c[grant]_z_ack, set c[grant]_z_stb<=0, done_cnt[grant]+=1 (wraps to 0 at 2^CNT_W-1+1), last_grant<=grant, go to IDLE.
- Ungranted client:
  - Its ack and z_stb stay 0.
  - Its stb may stay high indefinitely and is served on the next IDLE visit.
  - It is guaranteed service within one operation of the other client.
- Client stb dropped in ACCEPT before the transfer: this is a protocol violation. The arbiter waits in ACCEPT with ack high; behaviour is unspecified beyond that.
- Only one of c0_ack, c1_ack, c0_z_stb, c1_z_stb is high at any time.
- The quotient is passed through bit-exact; the arbiter does no arithmetic on operands or results.
- Back-to-back: IDLE is revisited for exactly one cycle between operations. Minimum arbiter overhead per operation, excluding divider time, is ACCEPT + SEND_A + SEND_B + WAIT_Z entry + PUT_Z + IDLE.

Test Plan:
- Client 0 alone: a=0x40C00000, b=0x40000000 (6.0/2.0) -> c0_z=0x40400000 with c0_z_stb. done_cnt0=1, done_cnt1=0, c1_ack never high.
- Both stb high in the same cycle after reset: c0 (1.0/3.0: 0x3F800000/0x40400000) and c1 (1.0/0.0) -> c0 served first with c0_z=0x3EAAAAAB, then c1_z=0x7F800000. Counts 1/1.
- Both clients hold stb continuously for 4 operations -> grants alternate 0,1,0,1. done_cnt0=2, done_cnt1=2.
- Divider stalls (div_a_ack held low 10 cycles, div_z_stb late 20 cycles) and client 1 holds c1_z_ack low 5 cycles -> div_a_stb, div_z_ack and c1_z_stb stay high with stable data until the transfer. No second operation starts.
- rst pulsed while in WAIT_Z -> next cycle: all stb/ack outputs 0, counters 0, state IDLE. The next request completes correctly.
- CNT_W=2, 5 client-0 operations -> done_cnt0 sequence 1,2,3,0,1.
